irq_sequencer: RTL and testbench
================================

// Module: irq_sequencer
// PURPOSE
//  Interrupt controller feeding the fetch stage. Latches edge-triggered requests and picks
//  one by fixed priority. Drives the one-shot alert/vector handshake into the PC-select
//  logic, then holds off further interrupts until return-from-interrupt. Sits beside IF;
//  consumes IF's interrupt/interrupt_mask/flush outputs and the decoded RETI (pci_take).
// PARAMETERS
//  NUM_SRC     4            number of request lines (2..16); index 0 = highest priority
//  VEC_BASE    32'h0000_0100 handler address for source 0
//  VEC_STRIDE  32'h10       byte spacing between consecutive source handlers
//  ACK_TIMEOUT 15           max cycles alert may wait for IF ack (1..255)
// PORTS
//  clk            in  1        clock, all state on rising edge
//  rst_n          in  1        asynchronous active-low reset
//  irq_req        in  NUM_SRC  request lines, rising edge = event
//  cfg_we         in  1        write enable for enable register
//  cfg_wdata      in  NUM_SRC  new enable mask
//  stall          in  1        pipeline stall from hazard unit
//  flush          in  1        IF flush (branch redirect in progress)
//  interrupt_mask in  1        IF mask; 1 = handler running
//  interrupt      in  1        IF ack: PCI captured this cycle
//  reti           in  1        return-from-interrupt (pci_take)
//  alert          out 1        request IF to vector (registered)
//  isr_vector     out 32       handler address, valid while alert=1
//  active_src     out $clog2(NUM_SRC)  source being serviced
//  in_service     out 1        1 from ack until reti
//  pending        out NUM_SRC  latched requests
//  irq_en         out NUM_SRC  enable register
//  ack_err        out 1        sticky: an alert timed out
// BEHAVIOUR
//  Reset: state=IDLE. alert/in_service/ack_err, pending, active_src and isr_vector = 0.
//  irq_en resets to all-ones; irq_req edge-history flops reset to 0.
//  Edge detect: irq_req[i] & ~prev[i] at edge k sets pending[i] after edge k.
//  Pending latches even when irq_en[i]=0.
//  Set/clear same cycle on same bit: set wins (bit stays 1).
//  cfg_we: irq_en <= cfg_wdata at the edge. Arbitration in that cycle uses the old irq_en.
//  eligible = pending & irq_en. winner = lowest set index.
//  FSM:
//   IDLE: eligible!=0 & !interrupt_mask & !stall & !flush -> ALERT.
//    Latch active_src=winner and isr_vector=VEC_BASE+winner*VEC_STRIDE (mod 2^32).
//    Load timeout cnt=0. alert=1 from the next cycle.
//   ALERT: alert held 1 (also during stall).
//    interrupt=1 -> SERVICE: alert<=0, pending[active_src]<=0, in_service<=1.
//    Else if flush=1 -> IDLE, alert<=0, pending kept (redirect cancelled request).
//    Else cnt++; cnt==ACK_TIMEOUT -> IDLE, alert<=0, ack_err<=1, pending kept.
//   SERVICE: no new alert. reti=1 -> IDLE, in_service<=0.
//    Re-arbitration is allowed the cycle after IDLE is reached.
//   reti seen in IDLE/ALERT: ignored.
//  Priority on simultaneous ALERT events: interrupt > flush > timeout.
//  Latency: edge at k -> pending after k -> ALERT after k+1 -> alert visible cycle k+2,
//  given no stall/flush/mask.
//  Reset mid-operation returns everything to reset values immediately (async).
// CONFIGURATION
//  IRQ_SYNC_EN defined: 2-flop synchronizer on each irq_req before edge detect.
//   Adds 2 cycles of latency (alert visible cycle k+4). Flops reset to 0.
//  IRQ_SYNC_EN undefined: irq_req used directly; it must be synchronous to clk.
// TESTING
//  T1 reset: rst_n=0 mid-ALERT -> alert=0, pending=0, irq_en=4'hF, state IDLE.
//  T2 irq_req[2] rises at edge 10, no stall -> alert=1 cycle 12, isr_vector=32'h120.
//   Ack at 13 -> in_service=1, pending[2]=0; reti at 20 -> in_service=0.
//  T3 irq_req=4'b1010 same edge -> src1 serviced first (vector 32'h110).
//   After reti, src3 alerted with 32'h130.
//  T4 irq_en=4'b1110, irq_req[0] edge -> pending[0]=1, no alert.
//   Write cfg 4'hF -> alert for src0 two cycles later.
//  T5 alert, no ack for 15 cycles -> alert drops, ack_err=1, pending kept, re-alert follows.
//  T6 stall=1 on alert cycle for 3 cycles, then ack -> alert held throughout.
//   flush during ALERT without ack -> alert drops, pending kept.

Source files
------------

// File: rtl/irq_sequencer.sv
// Edge-latched, fixed-priority interrupt sequencer that drives the alert/vector handshake into IF.
// Optional IRQ_SYNC_EN adds a 2-flop synchronizer on every irq_req line ahead of edge detection.
module irq_sequencer #(
    parameter int          NUM_SRC     = 4,
    parameter logic [31:0] VEC_BASE    = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE  = 32'h10,
    parameter int          ACK_TIMEOUT = 15,
    localparam int         SW          = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_req,
    input  logic               cfg_we,
    input  logic [NUM_SRC-1:0] cfg_wdata,
    input  logic               stall,
    input  logic               flush,
    input  logic               interrupt_mask,
    input  logic               interrupt,
    input  logic               reti,
    output logic               alert,
    output logic [31:0]        isr_vector,
    output logic [SW-1:0]      active_src,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] irq_en,
    output logic               ack_err
);

    typedef enum logic [1:0] {IDLE, ALERT, SERVICE} state_t;

    state_t             state, state_n;
    logic [7:0]         cnt, cnt_n;
    logic [NUM_SRC-1:0] req_s, prev, rise, eligible, pending_n;
    logic [SW-1:0]      winner;
    logic               latch, clr, err_set;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1, sync2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_req;
            sync2 <= sync1;
        end
    end
    assign req_s = sync2;
`else
    assign req_s = irq_req;
`endif

    assign rise     = req_s & ~prev;
    assign eligible = pending & irq_en;
    assign alert      = (state == ALERT);
    assign in_service = (state == SERVICE);

    // Scan high to low so the lowest eligible index is the last write.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (eligible[i]) winner = SW'(i);
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        latch   = 1'b0;
        clr     = 1'b0;
        err_set = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible && !interrupt_mask && !stall && !flush) begin
                    state_n = ALERT;
                    latch   = 1'b1;
                    cnt_n   = '0;
                end
            end
            ALERT: begin
                if (interrupt) begin
                    state_n = SERVICE;
                    clr     = 1'b1;
                end else if (flush) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                    if (cnt_n == 8'(ACK_TIMEOUT)) begin
                        state_n = IDLE;
                        err_set = 1'b1;
                    end
                end
            end
            SERVICE: if (reti) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // A fresh edge on the bit being acknowledged survives the clear.
    always_comb begin
        pending_n = pending;
        if (clr) pending_n[active_src] = 1'b0;
        pending_n = pending_n | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            prev       <= '0;
            pending    <= '0;
            irq_en     <= '1;
            active_src <= '0;
            isr_vector <= '0;
            ack_err    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            prev    <= req_s;
            pending <= pending_n;
            if (cfg_we) irq_en <= cfg_wdata;
            if (latch) begin
                active_src <= winner;
                isr_vector <= VEC_BASE + 32'(winner) * VEC_STRIDE;
            end
            if (err_set) ack_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed checks of irq_sequencer: latency, priority, enable masking, timeout, stall and flush.
module tb_irq_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  irq_req;
    logic        cfg_we;
    logic [3:0]  cfg_wdata;
    logic        stall, flush, interrupt_mask, interrupt, reti;
    logic        alert, in_service, ack_err;
    logic [31:0] isr_vector;
    logic [1:0]  active_src;
    logic [3:0]  pending, irq_en;

    int checks = 0;
    int errors = 0;

    irq_sequencer dut (
        .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
        .stall(stall), .flush(flush), .interrupt_mask(interrupt_mask), .interrupt(interrupt),
        .reti(reti), .alert(alert), .isr_vector(isr_vector), .active_src(active_src),
        .in_service(in_service), .pending(pending), .irq_en(irq_en), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_and_return();
        interrupt = 1'b1;
        step();
        interrupt = 1'b0;
        reti = 1'b1;
        step();
        reti = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; irq_req = '0; cfg_we = 1'b0; cfg_wdata = '0;
        stall = 1'b0; flush = 1'b0; interrupt_mask = 1'b0; interrupt = 1'b0; reti = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_alert", 32'(alert), 32'd0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_irq_en", 32'(irq_en), 32'hF);
        chk("rst_vector", isr_vector, 32'h0);
        chk("rst_insvc", 32'(in_service), 32'd0);
        chk("rst_ackerr", 32'(ack_err), 32'd0);

        // T2: single source 2
        irq_req = 4'b0100;
        step();
        chk("t2_pending", 32'(pending), 32'h4);
        chk("t2_no_alert_yet", 32'(alert), 32'd0);
        step();
        irq_req = '0;
        chk("t2_alert", 32'(alert), 32'd1);
        chk("t2_vector", isr_vector, 32'h120);
        chk("t2_src", 32'(active_src), 32'd2);
        interrupt = 1'b1;
        step();
        interrupt = 1'b0;
        chk("t2_insvc", 32'(in_service), 32'd1);
        chk("t2_alert_low", 32'(alert), 32'd0);
        chk("t2_pending_clr", 32'(pending), 32'h0);
        repeat (4) step();
        chk("t2_insvc_hold", 32'(in_service), 32'd1);
        reti = 1'b1;
        step();
        reti = 1'b0;
        chk("t2_reti", 32'(in_service), 32'd0);

        // T3: two sources on the same edge, lower index first
        irq_req = 4'b1010;
        step();
        irq_req = '0;
        chk("t3_pending", 32'(pending), 32'hA);
        step();
        chk("t3_vec1", isr_vector, 32'h110);
        chk("t3_src1", 32'(active_src), 32'd1);
        interrupt = 1'b1;
        step();
        interrupt = 1'b0;
        chk("t3_pending_left", 32'(pending), 32'h8);
        reti = 1'b1;
        step();
        reti = 1'b0;
        chk("t3_idle_gap", 32'(alert), 32'd0);
        step();
        chk("t3_alert3", 32'(alert), 32'd1);
        chk("t3_vec3", isr_vector, 32'h130);
        ack_and_return();
        chk("t3_drained", 32'(pending), 32'h0);

        // T4: disabled source latches but does not alert until enabled
        cfg_we = 1'b1; cfg_wdata = 4'b1110;
        step();
        cfg_we = 1'b0;
        chk("t4_en", 32'(irq_en), 32'hE);
        irq_req = 4'b0001;
        step();
        irq_req = '0;
        chk("t4_pending", 32'(pending), 32'h1);
        repeat (3) step();
        chk("t4_masked", 32'(alert), 32'd0);
        cfg_we = 1'b1; cfg_wdata = 4'hF;
        step();
        cfg_we = 1'b0;
        chk("t4_old_en_used", 32'(alert), 32'd0);
        step();
        chk("t4_alert0", 32'(alert), 32'd1);
        chk("t4_vec0", isr_vector, 32'h100);
        ack_and_return();

        // interrupt_mask holds off arbitration
        interrupt_mask = 1'b1;
        irq_req = 4'b0010;
        step();
        irq_req = '0;
        repeat (3) step();
        chk("mask_block", 32'(alert), 32'd0);
        interrupt_mask = 1'b0;
        step();
        chk("mask_release", 32'(alert), 32'd1);
        ack_and_return();

        // T5: ack timeout after 15 alert cycles
        irq_req = 4'b1000;
        step();
        irq_req = '0;
        step();
        n = 0;
        while (alert && n < 40) begin
            n++;
            step();
        end
        chk("t5_alert_cycles", 32'(n), 32'd15);
        chk("t5_ackerr", 32'(ack_err), 32'd1);
        chk("t5_pending_kept", 32'(pending), 32'h8);
        step();
        chk("t5_realert", 32'(alert), 32'd1);
        chk("t5_realert_vec", isr_vector, 32'h130);
        ack_and_return();
        chk("t5_ackerr_sticky", 32'(ack_err), 32'd1);

        // T6: stall holds alert; flush cancels
        irq_req = 4'b0001;
        step();
        irq_req = '0;
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t6_stall_hold", 32'(alert), 32'd1);
            step();
        end
        stall = 1'b0;
        chk("t6_stall_end", 32'(alert), 32'd1);
        interrupt = 1'b1;
        step();
        interrupt = 1'b0;
        chk("t6_ack", 32'(in_service), 32'd1);
        reti = 1'b1;
        step();
        reti = 1'b0;
        irq_req = 4'b0010;
        step();
        irq_req = '0;
        step();
        chk("t6_alert1", 32'(alert), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t6_flush_drop", 32'(alert), 32'd0);
        chk("t6_flush_pending", 32'(pending), 32'h2);
        chk("t6_flush_nosvc", 32'(in_service), 32'd0);
        step();
        chk("t6_after_flush", 32'(alert), 32'd1);
        interrupt = 1'b1; flush = 1'b1;
        step();
        interrupt = 1'b0; flush = 1'b0;
        chk("t6_ack_beats_flush", 32'(in_service), 32'd1);
        reti = 1'b1;
        step();
        reti = 1'b0;

        // T1: async reset in the middle of ALERT
        cfg_we = 1'b1; cfg_wdata = 4'b0110;
        irq_req = 4'b0100;
        step();
        cfg_we = 1'b0;
        irq_req = '0;
        step();
        chk("t1_pre_alert", 32'(alert), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_alert", 32'(alert), 32'd0);
        chk("t1_pending", 32'(pending), 32'h0);
        chk("t1_irq_en", 32'(irq_en), 32'hF);
        chk("t1_ackerr", 32'(ack_err), 32'd0);
        chk("t1_vector", isr_vector, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("t1_idle", 32'(alert), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
